// File: rtl/e203_itcm_arb_pkg.sv
// ---------------------------------------------------------------------------
// e203_itcm_arb_pkg
//   Shared definitions for the ITCM arbiter slice:
//   - requester ID encoding stored in the outstanding-ID FIFO
//   - default ITCM address / data widths
// ---------------------------------------------------------------------------
package e203_itcm_arb_pkg;

  // Default ITCM byte-address and data widths.
  localparam int ITCM_AW_DEFAULT = 16;
  localparam int ITCM_DW_DEFAULT = 64;

  // Requester that issued a command; one bit per outstanding entry.
  typedef enum logic {
    ID_IFU = 1'b0,
    ID_LSU = 1'b1
  } req_id_t;

endpackage : e203_itcm_arb_pkg

// File: rtl/e203_itcm_arb_idfifo.sv
// ---------------------------------------------------------------------------
// e203_itcm_arb_idfifo
//   Synchronous FIFO of requester IDs, one entry per outstanding ITCM command.
//   Commands complete in order, so the head entry always names the requester
//   that owns the next ITCM response.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (discards all entries)
//   push        write push_id (ignored when full)
//   push_id     requester ID of the command being issued
//   pop         drop the head entry (ignored when empty)
//   head_id     ID at the head of the FIFO (valid only when !empty)
//   full        DEPTH entries held
//   empty       no entries held
// ---------------------------------------------------------------------------
module e203_itcm_arb_idfifo
  import e203_itcm_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output req_id_t head_id,
  output logic    full,
  output logic    empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_id_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               push_en;
  logic               pop_en;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      // NOTE: the ID storage is only a few flops, so it is reset as well; the
      // head entry then never carries X into the response routing logic.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= ID_IFU;
      end
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_en, pop_en})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_id = mem[rd_ptr];
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);

endmodule : e203_itcm_arb_idfifo

// File: rtl/e203_itcm_arb.sv
// ---------------------------------------------------------------------------
// e203_itcm_arb
//   Shares the single ITCM ICB port between the IFU fetch path (read-only)
//   and the LSU path (read/write).
//   - LSU has fixed priority, except that a waiting IFU which has lost STARVE
//     consecutive grants to the LSU is forced to win the next one.
//   - A command stalled by the ITCM (valid & !ready) locks the grant until it
//     handshakes, so the presented command never changes under a stall.
//   - An in-order ID FIFO remembers who issued each accepted command and
//     routes each ITCM response back to that requester.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   ifu_icb_cmd_*            IFU fetch command (read-only)
//   ifu_icb_rsp_*            IFU response
//   lsu_icb_cmd_*            LSU command (read or write)
//   lsu_icb_rsp_*            LSU response
//   itcm_icb_cmd_*           merged command to the ITCM controller
//   itcm_icb_rsp_*           response from the ITCM controller
// ---------------------------------------------------------------------------
module e203_itcm_arb
  import e203_itcm_arb_pkg::*;
#(
  parameter int AW     = ITCM_AW_DEFAULT,
  parameter int DW     = ITCM_DW_DEFAULT,
  parameter int OUTS_N = 2,
  parameter int STARVE = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            ifu_icb_cmd_valid,
  output logic            ifu_icb_cmd_ready,
  input  logic [AW-1:0]   ifu_icb_cmd_addr,
  output logic            ifu_icb_rsp_valid,
  input  logic            ifu_icb_rsp_ready,
  output logic            ifu_icb_rsp_err,
  output logic [DW-1:0]   ifu_icb_rsp_rdata,

  input  logic            lsu_icb_cmd_valid,
  output logic            lsu_icb_cmd_ready,
  input  logic [AW-1:0]   lsu_icb_cmd_addr,
  input  logic            lsu_icb_cmd_read,
  input  logic [DW-1:0]   lsu_icb_cmd_wdata,
  input  logic [DW/8-1:0] lsu_icb_cmd_wmask,
  output logic            lsu_icb_rsp_valid,
  input  logic            lsu_icb_rsp_ready,
  output logic            lsu_icb_rsp_err,
  output logic [DW-1:0]   lsu_icb_rsp_rdata,

  output logic            itcm_icb_cmd_valid,
  input  logic            itcm_icb_cmd_ready,
  output logic [AW-1:0]   itcm_icb_cmd_addr,
  output logic            itcm_icb_cmd_read,
  output logic [DW-1:0]   itcm_icb_cmd_wdata,
  output logic [DW/8-1:0] itcm_icb_cmd_wmask,
  input  logic            itcm_icb_rsp_valid,
  output logic            itcm_icb_rsp_ready,
  input  logic            itcm_icb_rsp_err,
  input  logic [DW-1:0]   itcm_icb_rsp_rdata
);

  localparam int STARVE_W = $clog2(STARVE + 1);

  // ---------------- state ----------------
  logic                lock;
  req_id_t             lock_id;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_nxt;

  // ---------------- grant ----------------
  req_id_t grant_id;
  logic    granted_valid;
  logic    starve_hit;
  logic    fifo_full;
  logic    fifo_empty;
  req_id_t head_id;
  logic    cmd_hs;
  logic    ifu_hs;
  logic    lsu_hs;
  logic    rsp_hs;

  assign starve_hit = (starve_cnt == STARVE_W'(STARVE));

  // NOTE: every signal driven in an always_comb gets a default at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    grant_id = ID_LSU;
    if (lock) begin
      grant_id = lock_id;
    end else if (ifu_icb_cmd_valid && (!lsu_icb_cmd_valid || starve_hit)) begin
      grant_id = ID_IFU;
    end
  end

  assign granted_valid = (grant_id == ID_IFU) ? ifu_icb_cmd_valid : lsu_icb_cmd_valid;

  // ---------------- command path ----------------
  // A full FIFO blocks the command even when a response pops in the same
  // cycle; this keeps cmd_ready free of a path from itcm_icb_rsp_valid.
  assign itcm_icb_cmd_valid = granted_valid && !fifo_full;

  // Ready is also qualified by the granted requester's own valid, so an idle
  // requester never sees ready.
  assign ifu_icb_cmd_ready = (grant_id == ID_IFU) && ifu_icb_cmd_valid
                             && itcm_icb_cmd_ready && !fifo_full;
  assign lsu_icb_cmd_ready = (grant_id == ID_LSU) && lsu_icb_cmd_valid
                             && itcm_icb_cmd_ready && !fifo_full;

  always_comb begin
    itcm_icb_cmd_addr  = lsu_icb_cmd_addr;
    itcm_icb_cmd_read  = lsu_icb_cmd_read;
    itcm_icb_cmd_wdata = lsu_icb_cmd_wdata;
    itcm_icb_cmd_wmask = lsu_icb_cmd_wmask;
    if (grant_id == ID_IFU) begin
      itcm_icb_cmd_addr  = ifu_icb_cmd_addr;
      itcm_icb_cmd_read  = 1'b1;
      itcm_icb_cmd_wdata = '0;
      itcm_icb_cmd_wmask = '0;
    end
  end

  assign cmd_hs = itcm_icb_cmd_valid && itcm_icb_cmd_ready;
  assign ifu_hs = cmd_hs && (grant_id == ID_IFU);
  assign lsu_hs = cmd_hs && (grant_id == ID_LSU);

  // ---------------- lock and starvation ----------------
  always_comb begin
    starve_nxt = starve_cnt;
    if (!ifu_icb_cmd_valid || ifu_hs) begin
      starve_nxt = '0;
    end else if (lsu_hs && !starve_hit) begin
      starve_nxt = starve_cnt + STARVE_W'(1);
    end
  end

  // The lock is re-evaluated every cycle: it holds while the ITCM stalls the
  // presented command and drops on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock       <= 1'b0;
      lock_id    <= ID_IFU;
      starve_cnt <= '0;
    end else begin
      lock       <= itcm_icb_cmd_valid && !itcm_icb_cmd_ready;
      lock_id    <= grant_id;
      starve_cnt <= starve_nxt;
    end
  end

  // ---------------- outstanding-ID FIFO ----------------
  e203_itcm_arb_idfifo #(
    .DEPTH (OUTS_N)
  ) u_idfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_hs),
    .push_id (grant_id),
    .pop     (rsp_hs),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---------------- response path ----------------
  // An empty FIFO means no owner for a response, so it is never accepted.
  assign ifu_icb_rsp_valid  = itcm_icb_rsp_valid && !fifo_empty && (head_id == ID_IFU);
  assign lsu_icb_rsp_valid  = itcm_icb_rsp_valid && !fifo_empty && (head_id == ID_LSU);
  assign itcm_icb_rsp_ready = !fifo_empty
                              && ((head_id == ID_IFU) ? ifu_icb_rsp_ready : lsu_icb_rsp_ready);
  assign rsp_hs             = itcm_icb_rsp_valid && itcm_icb_rsp_ready;

  assign ifu_icb_rsp_err    = itcm_icb_rsp_err;
  assign lsu_icb_rsp_err    = itcm_icb_rsp_err;
  assign ifu_icb_rsp_rdata  = itcm_icb_rsp_rdata;
  assign lsu_icb_rsp_rdata  = itcm_icb_rsp_rdata;

  // A response with nothing outstanding means the ITCM controller and the
  // arbiter have lost track of each other.
  rsp_without_cmd: assert property (
    @(posedge clk) disable iff (!rst_n) !(itcm_icb_rsp_valid && fifo_empty)
  ) else $error("itcm response arrived with no outstanding command");

endmodule : e203_itcm_arb

// File: tb/tb_e203_itcm_arb.sv
// ---------------------------------------------------------------------------
// tb_e203_itcm_arb
//   Directed bench for e203_itcm_arb with default parameters
//   (AW=16, DW=64, OUTS_N=2, STARVE=4). Inputs change 1 time unit after the
//   rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_e203_itcm_arb;

  localparam int AW = 16;
  localparam int DW = 64;

  logic            clk;
  logic            rst_n;
  logic            ifu_icb_cmd_valid;
  logic            ifu_icb_cmd_ready;
  logic [AW-1:0]   ifu_icb_cmd_addr;
  logic            ifu_icb_rsp_valid;
  logic            ifu_icb_rsp_ready;
  logic            ifu_icb_rsp_err;
  logic [DW-1:0]   ifu_icb_rsp_rdata;
  logic            lsu_icb_cmd_valid;
  logic            lsu_icb_cmd_ready;
  logic [AW-1:0]   lsu_icb_cmd_addr;
  logic            lsu_icb_cmd_read;
  logic [DW-1:0]   lsu_icb_cmd_wdata;
  logic [DW/8-1:0] lsu_icb_cmd_wmask;
  logic            lsu_icb_rsp_valid;
  logic            lsu_icb_rsp_ready;
  logic            lsu_icb_rsp_err;
  logic [DW-1:0]   lsu_icb_rsp_rdata;
  logic            itcm_icb_cmd_valid;
  logic            itcm_icb_cmd_ready;
  logic [AW-1:0]   itcm_icb_cmd_addr;
  logic            itcm_icb_cmd_read;
  logic [DW-1:0]   itcm_icb_cmd_wdata;
  logic [DW/8-1:0] itcm_icb_cmd_wmask;
  logic            itcm_icb_rsp_valid;
  logic            itcm_icb_rsp_ready;
  logic            itcm_icb_rsp_err;
  logic [DW-1:0]   itcm_icb_rsp_rdata;

  int total = 0;
  int bad   = 0;

  e203_itcm_arb #(.AW(AW), .DW(DW), .OUTS_N(2), .STARVE(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ifu_icb_cmd_valid  (ifu_icb_cmd_valid),
    .ifu_icb_cmd_ready  (ifu_icb_cmd_ready),
    .ifu_icb_cmd_addr   (ifu_icb_cmd_addr),
    .ifu_icb_rsp_valid  (ifu_icb_rsp_valid),
    .ifu_icb_rsp_ready  (ifu_icb_rsp_ready),
    .ifu_icb_rsp_err    (ifu_icb_rsp_err),
    .ifu_icb_rsp_rdata  (ifu_icb_rsp_rdata),
    .lsu_icb_cmd_valid  (lsu_icb_cmd_valid),
    .lsu_icb_cmd_ready  (lsu_icb_cmd_ready),
    .lsu_icb_cmd_addr   (lsu_icb_cmd_addr),
    .lsu_icb_cmd_read   (lsu_icb_cmd_read),
    .lsu_icb_cmd_wdata  (lsu_icb_cmd_wdata),
    .lsu_icb_cmd_wmask  (lsu_icb_cmd_wmask),
    .lsu_icb_rsp_valid  (lsu_icb_rsp_valid),
    .lsu_icb_rsp_ready  (lsu_icb_rsp_ready),
    .lsu_icb_rsp_err    (lsu_icb_rsp_err),
    .lsu_icb_rsp_rdata  (lsu_icb_rsp_rdata),
    .itcm_icb_cmd_valid (itcm_icb_cmd_valid),
    .itcm_icb_cmd_ready (itcm_icb_cmd_ready),
    .itcm_icb_cmd_addr  (itcm_icb_cmd_addr),
    .itcm_icb_cmd_read  (itcm_icb_cmd_read),
    .itcm_icb_cmd_wdata (itcm_icb_cmd_wdata),
    .itcm_icb_cmd_wmask (itcm_icb_cmd_wmask),
    .itcm_icb_rsp_valid (itcm_icb_rsp_valid),
    .itcm_icb_rsp_ready (itcm_icb_rsp_ready),
    .itcm_icb_rsp_err   (itcm_icb_rsp_err),
    .itcm_icb_rsp_rdata (itcm_icb_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_icb_cmd_valid  = 1'b0;
    ifu_icb_cmd_addr   = '0;
    ifu_icb_rsp_ready  = 1'b1;
    lsu_icb_cmd_valid  = 1'b0;
    lsu_icb_cmd_addr   = '0;
    lsu_icb_cmd_read   = 1'b1;
    lsu_icb_cmd_wdata  = '0;
    lsu_icb_cmd_wmask  = '0;
    lsu_icb_rsp_ready  = 1'b1;
    itcm_icb_cmd_ready = 1'b1;
    itcm_icb_rsp_valid = 1'b0;
    itcm_icb_rsp_err   = 1'b0;
    itcm_icb_rsp_rdata = '0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    total++; if (itcm_icb_cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_itcm_cmd_valid: got %b want 0", itcm_icb_cmd_valid); end
    total++; if ({ifu_icb_cmd_ready, lsu_icb_cmd_ready} !== 2'b00) begin bad++; $display("FAIL rst_cmd_ready: got %b want 00", {ifu_icb_cmd_ready, lsu_icb_cmd_ready}); end
    total++; if ({ifu_icb_rsp_valid, lsu_icb_rsp_valid, itcm_icb_rsp_ready} !== 3'b000) begin bad++; $display("FAIL rst_rsp_flags: got %b want 000", {ifu_icb_rsp_valid, lsu_icb_rsp_valid, itcm_icb_rsp_ready}); end
    total++; if ($isunknown({itcm_icb_cmd_addr, itcm_icb_cmd_wdata, itcm_icb_cmd_wmask, itcm_icb_cmd_read}) !== 1'b0) begin bad++; $display("FAIL rst_cmd_data_known: X present on itcm cmd data"); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_ifu_fetch();
    ifu_icb_cmd_valid = 1'b1;
    ifu_icb_cmd_addr  = 16'h0100;
    @(negedge clk);
    total++; if (itcm_icb_cmd_valid !== 1'b1) begin bad++; $display("FAIL fetch_cmd_valid: got %b want 1", itcm_icb_cmd_valid); end
    total++; if (itcm_icb_cmd_addr !== 16'h0100) begin bad++; $display("FAIL fetch_cmd_addr: got %h want 0100", itcm_icb_cmd_addr); end
    total++; if ({itcm_icb_cmd_read, itcm_icb_cmd_wmask} !== 9'h100) begin bad++; $display("FAIL fetch_read_wmask: got %h want 100", {itcm_icb_cmd_read, itcm_icb_cmd_wmask}); end
    total++; if (itcm_icb_cmd_wdata !== 64'h0) begin bad++; $display("FAIL fetch_wdata: got %h want 0", itcm_icb_cmd_wdata); end
    total++; if ({ifu_icb_cmd_ready, lsu_icb_cmd_ready} !== 2'b10) begin bad++; $display("FAIL fetch_cmd_ready: got %b want 10", {ifu_icb_cmd_ready, lsu_icb_cmd_ready}); end
    tick();
    ifu_icb_cmd_valid  = 1'b0;
    itcm_icb_rsp_valid = 1'b1;
    itcm_icb_rsp_rdata = 64'hDEADBEEF_00000013;
    @(negedge clk);
    total++; if ({ifu_icb_rsp_valid, lsu_icb_rsp_valid} !== 2'b10) begin bad++; $display("FAIL fetch_rsp_valid: got %b want 10", {ifu_icb_rsp_valid, lsu_icb_rsp_valid}); end
    total++; if (ifu_icb_rsp_rdata !== 64'hDEADBEEF_00000013) begin bad++; $display("FAIL fetch_rsp_rdata: got %h want deadbeef00000013", ifu_icb_rsp_rdata); end
    total++; if (itcm_icb_rsp_ready !== 1'b1) begin bad++; $display("FAIL fetch_itcm_rsp_ready: got %b want 1", itcm_icb_rsp_ready); end
    tick();
    itcm_icb_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if ({ifu_icb_rsp_valid, itcm_icb_rsp_ready} !== 2'b00) begin bad++; $display("FAIL fetch_after_pop: got %b want 00", {ifu_icb_rsp_valid, itcm_icb_rsp_ready}); end
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Both requesters valid every cycle; the bench answers each command one
  // cycle later, so the FIFO never fills. Expected grants L L L L I L L L L I.
  task automatic test_starvation();
    logic [9:0] exp_ifu;
    logic       prev_hs;
    logic       prev_ifu;
    exp_ifu  = 10'b10_0001_0000;
    prev_hs  = 1'b0;
    prev_ifu = 1'b0;
    ifu_icb_cmd_valid = 1'b1;
    ifu_icb_cmd_addr  = 16'h0500;
    lsu_icb_cmd_valid = 1'b1;
    lsu_icb_cmd_addr  = 16'h0080;
    lsu_icb_cmd_read  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      itcm_icb_rsp_valid = prev_hs;
      itcm_icb_rsp_rdata = 64'(i);
      @(negedge clk);
      total++;
      if ({ifu_icb_cmd_ready, lsu_icb_cmd_ready} !== (exp_ifu[i] ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL starve_grant[%0d]: got %b want %b", i, {ifu_icb_cmd_ready, lsu_icb_cmd_ready}, (exp_ifu[i] ? 2'b10 : 2'b01));
      end
      if (i > 0) begin
        total++;
        if ({ifu_icb_rsp_valid, lsu_icb_rsp_valid} !== (prev_ifu ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL starve_rsp_route[%0d]: got %b want %b", i, {ifu_icb_rsp_valid, lsu_icb_rsp_valid}, (prev_ifu ? 2'b10 : 2'b01));
        end
      end
      prev_hs  = itcm_icb_cmd_valid && itcm_icb_cmd_ready;
      prev_ifu = exp_ifu[i];
      tick();
    end
    ifu_icb_cmd_valid  = 1'b0;
    lsu_icb_cmd_valid  = 1'b0;
    itcm_icb_rsp_valid = prev_hs;
    tick();
    itcm_icb_rsp_valid = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_lock();
    ifu_icb_cmd_valid  = 1'b1;
    ifu_icb_cmd_addr   = 16'h0200;
    itcm_icb_cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        lsu_icb_cmd_valid = 1'b1;
        lsu_icb_cmd_addr  = 16'h0300;
        lsu_icb_cmd_read  = 1'b1;
      end
      @(negedge clk);
      total++; if ({itcm_icb_cmd_valid, itcm_icb_cmd_addr} !== {1'b1, 16'h0200}) begin bad++; $display("FAIL lock_stall_cmd[%0d]: got %b/%h want 1/0200", i, itcm_icb_cmd_valid, itcm_icb_cmd_addr); end
      total++; if ({ifu_icb_cmd_ready, lsu_icb_cmd_ready} !== 2'b00) begin bad++; $display("FAIL lock_stall_ready[%0d]: got %b want 00", i, {ifu_icb_cmd_ready, lsu_icb_cmd_ready}); end
      tick();
    end
    itcm_icb_cmd_ready = 1'b1;
    @(negedge clk);
    total++; if ({ifu_icb_cmd_ready, lsu_icb_cmd_ready, itcm_icb_cmd_addr} !== {2'b10, 16'h0200}) begin bad++; $display("FAIL lock_release: got %b/%h want 10/0200", {ifu_icb_cmd_ready, lsu_icb_cmd_ready}, itcm_icb_cmd_addr); end
    tick();
    ifu_icb_cmd_valid = 1'b0;
    @(negedge clk);
    total++; if ({ifu_icb_cmd_ready, lsu_icb_cmd_ready, itcm_icb_cmd_addr} !== {2'b01, 16'h0300}) begin bad++; $display("FAIL lock_next_lsu: got %b/%h want 01/0300", {ifu_icb_cmd_ready, lsu_icb_cmd_ready}, itcm_icb_cmd_addr); end
    tick();
    lsu_icb_cmd_valid  = 1'b0;
    itcm_icb_rsp_valid = 1'b1;
    @(negedge clk);
    total++; if ({ifu_icb_rsp_valid, lsu_icb_rsp_valid} !== 2'b10) begin bad++; $display("FAIL lock_rsp0: got %b want 10", {ifu_icb_rsp_valid, lsu_icb_rsp_valid}); end
    tick();
    @(negedge clk);
    total++; if ({ifu_icb_rsp_valid, lsu_icb_rsp_valid} !== 2'b01) begin bad++; $display("FAIL lock_rsp1: got %b want 01", {ifu_icb_rsp_valid, lsu_icb_rsp_valid}); end
    tick();
    itcm_icb_rsp_valid = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_full();
    lsu_icb_cmd_valid = 1'b1;
    lsu_icb_cmd_read  = 1'b0;
    lsu_icb_cmd_addr  = 16'h0010;
    lsu_icb_cmd_wdata = 64'h0123_4567_89AB_CDEF;
    lsu_icb_cmd_wmask = 8'hF0;
    @(negedge clk);
    total++; if ({lsu_icb_cmd_ready, itcm_icb_cmd_read, itcm_icb_cmd_wmask} !== {2'b10, 8'hF0}) begin bad++; $display("FAIL full_wr0_ctrl: got %b/%h want 10/f0", {lsu_icb_cmd_ready, itcm_icb_cmd_read}, itcm_icb_cmd_wmask); end
    total++; if (itcm_icb_cmd_wdata !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL full_wr0_wdata: got %h want 0123456789abcdef", itcm_icb_cmd_wdata); end
    tick();
    lsu_icb_cmd_addr = 16'h0018;
    @(negedge clk);
    total++; if (lsu_icb_cmd_ready !== 1'b1) begin bad++; $display("FAIL full_wr1_ready: got %b want 1", lsu_icb_cmd_ready); end
    tick();
    lsu_icb_cmd_addr   = 16'h0020;
    itcm_icb_rsp_valid = 1'b1;
    @(negedge clk);
    total++; if ({lsu_icb_cmd_ready, itcm_icb_cmd_valid} !== 2'b00) begin bad++; $display("FAIL full_blocked: got %b want 00", {lsu_icb_cmd_ready, itcm_icb_cmd_valid}); end
    total++; if ({lsu_icb_rsp_valid, itcm_icb_rsp_ready} !== 2'b11) begin bad++; $display("FAIL full_pop: got %b want 11", {lsu_icb_rsp_valid, itcm_icb_rsp_ready}); end
    tick();
    itcm_icb_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if ({lsu_icb_cmd_ready, itcm_icb_cmd_addr} !== {1'b1, 16'h0020}) begin bad++; $display("FAIL full_third_accept: got %b/%h want 1/0020", lsu_icb_cmd_ready, itcm_icb_cmd_addr); end
    tick();
    lsu_icb_cmd_valid  = 1'b0;
    itcm_icb_rsp_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if ({ifu_icb_rsp_valid, lsu_icb_rsp_valid} !== 2'b01) begin bad++; $display("FAIL full_drain[%0d]: got %b want 01", i, {ifu_icb_rsp_valid, lsu_icb_rsp_valid}); end
      tick();
    end
    itcm_icb_rsp_valid = 1'b0;
    lsu_icb_cmd_read   = 1'b1;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_rsp_order();
    ifu_icb_cmd_valid = 1'b1;
    ifu_icb_cmd_addr  = 16'h0400;
    lsu_icb_rsp_ready = 1'b0;
    tick();
    ifu_icb_cmd_valid  = 1'b0;
    lsu_icb_cmd_valid  = 1'b1;
    lsu_icb_cmd_addr   = 16'h0040;
    itcm_icb_rsp_valid = 1'b1;
    itcm_icb_rsp_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    total++; if ({ifu_icb_rsp_valid, lsu_icb_rsp_valid, itcm_icb_rsp_ready} !== 3'b101) begin bad++; $display("FAIL order_rsp_ifu: got %b want 101", {ifu_icb_rsp_valid, lsu_icb_rsp_valid, itcm_icb_rsp_ready}); end
    total++; if (lsu_icb_cmd_ready !== 1'b1) begin bad++; $display("FAIL order_lsu_cmd: got %b want 1", lsu_icb_cmd_ready); end
    tick();
    lsu_icb_cmd_valid  = 1'b0;
    itcm_icb_rsp_rdata = 64'h5555_6666_7777_8888;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if ({ifu_icb_rsp_valid, lsu_icb_rsp_valid, itcm_icb_rsp_ready} !== 3'b010) begin bad++; $display("FAIL order_hold[%0d]: got %b want 010", i, {ifu_icb_rsp_valid, lsu_icb_rsp_valid, itcm_icb_rsp_ready}); end
      tick();
    end
    lsu_icb_rsp_ready = 1'b1;
    itcm_icb_rsp_err  = 1'b1;
    @(negedge clk);
    total++; if ({lsu_icb_rsp_valid, itcm_icb_rsp_ready} !== 2'b11) begin bad++; $display("FAIL order_deliver: got %b want 11", {lsu_icb_rsp_valid, itcm_icb_rsp_ready}); end
    total++; if (lsu_icb_rsp_rdata !== 64'h5555_6666_7777_8888) begin bad++; $display("FAIL order_rdata: got %h want 5555666677778888", lsu_icb_rsp_rdata); end
    total++; if ({ifu_icb_rsp_err, lsu_icb_rsp_err} !== 2'b11) begin bad++; $display("FAIL order_err_fanout: got %b want 11", {ifu_icb_rsp_err, lsu_icb_rsp_err}); end
    tick();
    itcm_icb_rsp_valid = 1'b0;
    itcm_icb_rsp_err   = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    ifu_icb_cmd_valid = 1'b1;
    ifu_icb_cmd_addr  = 16'h0600;
    tick();
    ifu_icb_cmd_valid = 1'b0;
    lsu_icb_cmd_valid = 1'b1;
    lsu_icb_cmd_addr  = 16'h0060;
    tick();
    itcm_icb_cmd_ready = 1'b0;
    @(negedge clk);
    total++; if (itcm_icb_cmd_valid !== 1'b0) begin bad++; $display("FAIL rmid_full_before: got %b want 0", itcm_icb_cmd_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (itcm_icb_cmd_valid !== 1'b1) begin bad++; $display("FAIL rmid_fifo_cleared_async: got %b want 1", itcm_icb_cmd_valid); end
    lsu_icb_cmd_valid = 1'b0;
    #1;
    total++; if ({itcm_icb_cmd_valid, ifu_icb_cmd_ready, lsu_icb_cmd_ready, ifu_icb_rsp_valid, lsu_icb_rsp_valid, itcm_icb_rsp_ready} !== 6'b0) begin
      bad++; $display("FAIL rmid_outputs_idle: got %b want 000000", {itcm_icb_cmd_valid, ifu_icb_cmd_ready, lsu_icb_cmd_ready, ifu_icb_rsp_valid, lsu_icb_rsp_valid, itcm_icb_rsp_ready});
    end
    tick();
    rst_n              = 1'b1;
    itcm_icb_cmd_ready = 1'b1;
    tick();
    ifu_icb_cmd_valid = 1'b1;
    ifu_icb_cmd_addr  = 16'h0700;
    @(negedge clk);
    total++; if (ifu_icb_cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_resume_cmd0: got %b want 1", ifu_icb_cmd_ready); end
    tick();
    ifu_icb_cmd_valid = 1'b0;
    lsu_icb_cmd_valid = 1'b1;
    lsu_icb_cmd_addr  = 16'h0070;
    @(negedge clk);
    total++; if (lsu_icb_cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_resume_cmd1: got %b want 1", lsu_icb_cmd_ready); end
    tick();
    lsu_icb_cmd_valid  = 1'b0;
    itcm_icb_rsp_valid = 1'b1;
    @(negedge clk);
    total++; if ({ifu_icb_rsp_valid, lsu_icb_rsp_valid} !== 2'b10) begin bad++; $display("FAIL rmid_rsp0: got %b want 10", {ifu_icb_rsp_valid, lsu_icb_rsp_valid}); end
    tick();
    @(negedge clk);
    total++; if ({ifu_icb_rsp_valid, lsu_icb_rsp_valid} !== 2'b01) begin bad++; $display("FAIL rmid_rsp1: got %b want 01", {ifu_icb_rsp_valid, lsu_icb_rsp_valid}); end
    tick();
    itcm_icb_rsp_valid = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_ifu_fetch();
    test_starvation();
    test_lock();
    test_full();
    test_rsp_order();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_e203_itcm_arb

// File: doc/e203_itcm_arb.md
Name:
e203_itcm_arb

Overview:
- Shares the single ITCM ICB port between the IFU fetch path (read-only) and the LSU path (read/write).
- Fixed LSU priority with an IFU starvation guard.
- In-order outstanding-ID FIFO routes each ITCM response back to the requester that issued it.
- Sits between the IFU/LSU ITCM-bound ICB masters and the ITCM SRAM controller.

Parameters:
AW, 16, ITCM byte-address width
DW, 64, ITCM data width
OUTS_N, 2, maximum outstanding commands (depth of ID FIFO, >=1)
STARVE, 4, consecutive LSU grants lost by a waiting IFU before IFU is forced to win

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifu_icb_cmd_valid  in  1  IFU fetch request
ifu_icb_cmd_ready  out  1  IFU request accepted
ifu_icb_cmd_addr  in  AW  IFU fetch address
ifu_icb_rsp_valid  out  1  IFU response valid
ifu_icb_rsp_ready  in  1  IFU accepts response
ifu_icb_rsp_err  out  1  IFU response bus error
ifu_icb_rsp_rdata  out  DW  IFU response data
lsu_icb_cmd_valid  in  1  LSU request
lsu_icb_cmd_ready  out  1  LSU request accepted
lsu_icb_cmd_addr  in  AW  LSU address
lsu_icb_cmd_read  in  1  1=read, 0=write
lsu_icb_cmd_wdata  in  DW  LSU write data
lsu_icb_cmd_wmask  in  DW/8  LSU byte enables
lsu_icb_rsp_valid  out  1  LSU response valid
lsu_icb_rsp_ready  in  1  LSU accepts response
lsu_icb_rsp_err  out  1  LSU response error
lsu_icb_rsp_rdata  out  DW  LSU response data
itcm_icb_cmd_valid  out  1  command to ITCM
itcm_icb_cmd_ready  in  1  ITCM accepts command
itcm_icb_cmd_addr  out  AW  command address
itcm_icb_cmd_read  out  1  command read flag
itcm_icb_cmd_wdata  out  DW  command write data
itcm_icb_cmd_wmask  out  DW/8  command byte enables
itcm_icb_rsp_valid  in  1  ITCM response valid
itcm_icb_rsp_ready  out  1  arbiter accepts response
itcm_icb_rsp_err  in  1  ITCM response error
itcm_icb_rsp_rdata  in  DW  ITCM response data

Behaviour:
- **Reset (async, rst_n low):**
  - FIFO empty; starve_cnt=0; lock=0.
  - All valid and ready outputs are 0 while the FIFO is empty and no requester is valid.
  - Data outputs are don't-care but must be driven from registers/inputs, never X.
- **Grant:**
  - When not locked: grant IFU if ifu_valid & (!lsu_valid | starve_cnt==STARVE); otherwise grant LSU if lsu_valid.
  - Lock: if itcm_cmd_valid & !itcm_cmd_ready, register the grant. Next cycle, reuse the registered grant and ignore new priority.
  - Lock clears on handshake.
- **Command path (zero latency):**
  - itcm_cmd_valid = granted_valid & !full.
  - Granted requester's cmd_ready = itcm_cmd_ready & !full; the other requester's cmd_ready = 0.
  - For IFU commands: read=1, wdata=0, wmask=0.
  - full blocks a command even if a pop occurs in the same cycle.
- **ID FIFO:**
  - OUTS_N entries of 1 bit (0=IFU, 1=LSU); count width clog2(OUTS_N+1).
  - Push on itcm cmd handshake; pop on itcm rsp handshake.
  - Simultaneous push and pop are legal when not full; count is unchanged.
  - Read/write pointers wrap at OUTS_N.
- **Response path:**
  - Head ID selects the target requester: target rsp_valid = itcm_rsp_valid & !empty; itcm_rsp_ready = target rsp_ready.
  - The non-target requester's rsp_valid = 0.
  - err/rdata are fanned out to both requesters.
  - itcm_rsp_valid while the FIFO is empty: itcm_rsp_ready=0 and a simulation assertion fires.
- **Starvation counter:**
  - +1, saturating at STARVE, on each LSU cmd handshake while ifu_cmd_valid is high.
  - Cleared on IFU cmd handshake, or in any cycle ifu_cmd_valid is low.
- **Reset mid-operation:** outstanding IDs are discarded. Requesters and the ITCM controller share rst_n, so no orphaned response is expected.

Decomposition:
- Shared defines: requester ID encoding (ID_IFU=0, ID_LSU=1) and default AW/DW via gen_defines.v.
- One natural sub-module: e203_itcm_arb_idfifo (parameterised 1-bit sync FIFO with full/empty outputs).

Test Plan:
- IFU-only fetch at addr 0x0100, ITCM returns 0xDEADBEEF_00000013 after 1 cycle -> ifu_rsp_valid with that data; lsu_rsp_valid stays 0; itcm_cmd_read=1, wmask=0.
- Both requesters valid continuously, ITCM always ready, STARVE=4 -> grant sequence LSU,LSU,LSU,LSU,IFU,LSU,... with starve_cnt back to 0 after the IFU grant.
- IFU granted, itcm_cmd_ready low 3 cycles, LSU raises valid in cycle 1 -> grant stays IFU and addr stays stable until the handshake; LSU is granted the following cycle.
- OUTS_N=2: two commands accepted with no response -> third cmd_ready=0; one response popped -> third command accepted the next cycle.
- IFU cmd then LSU cmd; lsu_rsp_ready held low 2 cycles -> first response to IFU; second held with itcm_rsp_ready=0 for 2 cycles, then delivered to LSU.
- rst_n pulsed low with 2 commands outstanding -> FIFO empty, all valid outputs 0 asynchronously; normal operation resumes after release.
